// File: rtl/cache_control.sv
// Two-way set-associative cache controller: hit/miss handling, dirty-victim
// writeback, line allocation and saturating hit/miss performance counters.
module cache_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             v0,
  input  logic             v1,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic             lru,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             way_sel,
  output logic             valid_load,
  output logic             tag_load,
  output logic             data_load,
  output logic             dirty_load,
  output logic             lru_load,
  output logic             dirty_in,
  output logic             lru_in,
  output logic             wb_addr_sel,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   victim;
  logic   hit;
  logic   req;
  logic   miss_victim;
  logic   victim_dirty;

  assign hit          = hit0 | hit1;
  assign req          = mem_read | mem_write;
  // Invalid ways are filled before any LRU eviction.
  assign miss_victim  = (~v0) ? 1'b0 : (~v1) ? 1'b1 : lru;
  assign victim_dirty = miss_victim ? (v1 & dirty1) : (v0 & dirty0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      victim   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req) state <= COMPARE;
        COMPARE: begin
          if (hit) begin
            state <= IDLE;
            if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 1'b1;
          end else begin
            victim <= miss_victim;
            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
            state <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (pmem_resp) state <= ALLOCATE;
        ALLOCATE:  if (pmem_resp) state <= COMPARE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    way_sel     = 1'b0;
    valid_load  = 1'b0;
    tag_load    = 1'b0;
    data_load   = 1'b0;
    dirty_load  = 1'b0;
    lru_load    = 1'b0;
    dirty_in    = 1'b0;
    lru_in      = 1'b0;
    wb_addr_sel = 1'b0;
    case (state)
      COMPARE: begin
        if (hit) begin
          way_sel  = hit1;
          mem_resp = 1'b1;
          lru_load = 1'b1;
          lru_in   = ~hit1;
          if (mem_write) begin
            data_load  = 1'b1;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write  = 1'b1;
        wb_addr_sel = 1'b1;
        way_sel     = victim;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = victim;
        if (pmem_resp) begin
          data_load  = 1'b1;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Transaction-level reference bench for cache_control: each request is expanded
// into its expected per-cycle output trace, checked on every falling edge.
module tb_cache_control;

  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0, hit0 = 1'b0, hit1 = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, dirty0 = 1'b0, dirty1 = 1'b0, lru = 1'b0;
  logic pmem_resp = 1'b0;
  logic mem_resp, pmem_read, pmem_write, way_sel, valid_load, tag_load, data_load;
  logic dirty_load, lru_load, dirty_in, lru_in, wb_addr_sel;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  cache_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .hit0(hit0), .hit1(hit1), .v0(v0), .v1(v1), .dirty0(dirty0), .dirty1(dirty1),
    .lru(lru), .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .way_sel(way_sel), .valid_load(valid_load),
    .tag_load(tag_load), .data_load(data_load), .dirty_load(dirty_load),
    .lru_load(lru_load), .dirty_in(dirty_in), .lru_in(lru_in),
    .wb_addr_sel(wb_addr_sel), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic mem_resp, pmem_read, pmem_write, way_sel, valid_load, tag_load;
    logic data_load, dirty_load, lru_load, dirty_in, lru_in, wb_addr_sel;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [CNT_W-1:0] mh = '0, mm = '0;

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.hit_cnt  = mh;
    e.miss_cnt = mm;
    return e;
  endfunction

  function automatic exp_t hit_exp(input logic way, input logic is_wr);
    exp_t e;
    e = base();
    e.mem_resp = 1'b1;
    e.way_sel  = way;
    e.lru_load = 1'b1;
    e.lru_in   = ~way;
    e.data_load  = is_wr;
    e.dirty_load = is_wr;
    e.dirty_in   = is_wr;
    return e;
  endfunction

  task automatic bump_hit();
    if (mh != 4'd15) mh = mh + 1'b1;
  endtask

  task automatic bump_miss();
    if (mm != 4'd15) mm = mm + 1'b1;
  endtask

  // One clock cycle: apply inputs just after the rising edge, queue the outputs
  // that must be visible for the remainder of that cycle.
  task automatic drive(input logic rd, input logic wr, input logic h0, input logic h1,
                       input logic pr, input logic rst, input logic chk, input exp_t e);
    @(posedge clk);
    #1;
    mem_read = rd; mem_write = wr; hit0 = h0; hit1 = h1; pmem_resp = pr; reset = rst;
    if (chk) exp_q.push_back(e);
  endtask

  task automatic idle_cycle(input logic pr);
    drive(1'b0, 1'b0, 1'b0, 1'b0, pr, 1'b0, 1'b1, base());
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, base());
    mh = '0; mm = '0;
  endtask

  task automatic check_lit(input string name, input logic [CNT_W-1:0] got,
                           input logic [CNT_W-1:0] want);
    #1;
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Whole request from the IDLE cycle that sees it to the cycle carrying mem_resp.
  task automatic do_req(input logic is_wr, input logic hit, input logic hw,
                        input logic iv0, input logic iv1, input logic id0, input logic id1,
                        input logic ilru, input int wdly, input int adly, input logic noise);
    logic rd, wr, vic, wb;
    exp_t e;
    rd = ~is_wr; wr = is_wr;
    v0 = iv0; v1 = iv1; dirty0 = id0; dirty1 = id1; lru = ilru;
    drive(rd, wr, 1'b0, 1'b0, noise & $urandom_range(0, 1), 1'b0, 1'b1, base());
    if (hit) begin
      drive(rd, wr, ~hw, hw, noise & $urandom_range(0, 1), 1'b0, 1'b1, hit_exp(hw, is_wr));
      bump_hit();
      return;
    end
    drive(rd, wr, 1'b0, 1'b0, noise & $urandom_range(0, 1), 1'b0, 1'b1, base());
    bump_miss();
    vic = !iv0 ? 1'b0 : !iv1 ? 1'b1 : ilru;
    wb  = vic ? (iv1 & id1) : (iv0 & id0);
    if (wb) begin
      for (int i = 0; i <= wdly; i++) begin
        e = base();
        e.pmem_write = 1'b1; e.wb_addr_sel = 1'b1; e.way_sel = vic;
        drive(rd, wr, 1'b0, 1'b0, i == wdly, 1'b0, 1'b1, e);
      end
    end
    for (int i = 0; i <= adly; i++) begin
      e = base();
      e.pmem_read = 1'b1; e.way_sel = vic;
      if (i == adly) begin
        e.data_load = 1'b1; e.tag_load = 1'b1; e.valid_load = 1'b1; e.dirty_load = 1'b1;
      end
      drive(rd, wr, 1'b0, 1'b0, i == adly, 1'b0, 1'b1, e);
    end
    drive(rd, wr, ~vic, vic, noise & $urandom_range(0, 1), 1'b0, 1'b1, hit_exp(vic, is_wr));
    bump_hit();
  endtask

  // Single compare process over the queued expectations.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, g;
      e = exp_q.pop_front();
      g = {mem_resp, pmem_read, pmem_write, way_sel, valid_load, tag_load, data_load,
           dirty_load, lru_load, dirty_in, lru_in, wb_addr_sel, hit_cnt, miss_cnt};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got %b, expected %b", $time, g, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    do_reset();
    idle_cycle(1'b1);

    // Read hit on way1.
    do_req(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle_cycle(1'b0);
    check_lit("read_hit_hit_cnt", hit_cnt, 4'd1);

    // Cold miss, fill response three cycles after ALLOCATE entry.
    do_reset();
    do_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0);
    idle_cycle(1'b0);
    check_lit("cold_miss_miss_cnt", miss_cnt, 4'd1);
    check_lit("cold_miss_hit_cnt", hit_cnt, 4'd1);

    // Dirty eviction of way1, then write hit on way0.
    do_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1, 1'b0);
    do_req(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle_cycle(1'b0);
    check_lit("evict_write_hit_cnt", hit_cnt, 4'd3);
    check_lit("evict_write_miss_cnt", miss_cnt, 4'd2);

    // Reset in the middle of ALLOCATE, then a stray pmem_resp.
    v0 = 1'b1; v1 = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0; lru = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, base());
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, base());
    bump_miss();
    e = base(); e.pmem_read = 1'b1; e.way_sel = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e);
    e = base(); e.pmem_read = 1'b1; e.way_sel = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, e);
    mh = '0; mm = '0;
    idle_cycle(1'b1);
    check_lit("mid_alloc_reset_miss_cnt", miss_cnt, 4'd0);
    idle_cycle(1'b0);

    // Reset wins over a request presented in the same cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, base());
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, base());
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, hit_exp(1'b1, 1'b0));
    bump_hit();
    idle_cycle(1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic hit, hw;
      logic [4:0] r;
      r   = 5'($urandom);
      hit = $urandom_range(0, 1);
      hw  = $urandom_range(0, 1);
      if (hit) begin
        if (hw) r[1] = 1'b1; else r[0] = 1'b1;
      end
      do_req($urandom_range(0, 1), hit, hw, r[0], r[1], r[2], r[3], r[4],
             $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) idle_cycle($urandom_range(0, 1));
    end

    // Saturation: twenty hits with a 4-bit counter.
    idle_cycle(1'b0);
    do_reset();
    for (int n = 0; n < 20; n++)
      do_req(1'b0, 1'b1, n[0], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle_cycle(1'b0);
    check_lit("hit_cnt_saturation", hit_cnt, 4'd15);
    check_lit("miss_cnt_after_hits", miss_cnt, 4'd0);

    idle_cycle(1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, the width of the hit and miss counters.
REQ-002 The block SHALL have one clock and a synchronous active-high reset, named as in the port list below.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_read, mem_write  in  1 each  CPU request; the CPU holds the request until mem_resp; never both high.
REQ-006 hit0, hit1  in  1 each  tag match qualified by valid for way0/way1; never both high.
REQ-007 v0, v1  in  1 each  valid bits of the addressed set, from the valid-bit array.
REQ-008 dirty0, dirty1  in  1 each  dirty bits of the addressed set.
REQ-009 lru  in  1  least-recently-used way of the addressed set.
REQ-010 pmem_resp  in  1  physical memory done, one-cycle pulse.
REQ-011 mem_resp  out  1  CPU request complete, one-cycle pulse.
REQ-012 pmem_read, pmem_write  out  1 each  physical memory request, held until pmem_resp.
REQ-013 way_sel  out  1  target way; drives tag_sel of the valid-bit array.
REQ-014 valid_load, tag_load, data_load, dirty_load, lru_load  out  1 each  array write enables.
REQ-015 dirty_in, lru_in  out  1 each  write data for the dirty and LRU arrays.
REQ-016 wb_addr_sel  out  1  1 selects the victim tag as the pmem address; 0 selects the CPU address.
REQ-017 hit_cnt, miss_cnt  out  CNT_W each  performance counters.

Function
REQ-018 The states SHALL be IDLE, COMPARE, WRITEBACK and ALLOCATE; outputs are decoded from state and inputs, and every control output not listed for a state is 0.
REQ-019 IDLE: mem_read|mem_write -> COMPARE next cycle; otherwise stay in IDLE.
REQ-020 COMPARE hit (hit0|hit1) SHALL apply the following:
- way_sel = hit1.
- mem_resp = 1.
- lru_load = 1 and lru_in = ~hit1.
- For a write, also data_load = 1, dirty_load = 1 and dirty_in = 1.
- hit_cnt increments.
- Next state IDLE.
REQ-021 COMPARE miss SHALL register victim = (~v0) ? 0 : (~v1) ? 1 : lru; miss_cnt increments; no array write enables are asserted.
REQ-022 Miss next state: WRITEBACK if the victim's valid bit and dirty bit are both 1; otherwise ALLOCATE.
REQ-023 WRITEBACK SHALL drive pmem_write = 1, wb_addr_sel = 1 and way_sel = victim; on pmem_resp the next state is ALLOCATE.
REQ-024 ALLOCATE SHALL drive pmem_read = 1 and way_sel = victim.
REQ-025 On pmem_resp in ALLOCATE, the block SHALL assert the following for one cycle, then go to COMPARE:
- data_load, tag_load and valid_load.
- dirty_load = 1 with dirty_in = 0.
REQ-026 The re-entered COMPARE hits, so a clean miss completes in ≥4 cycles and mem_resp occurs exactly once per request.
REQ-027 pmem_resp SHALL be ignored in IDLE and COMPARE.
REQ-028 The victim register SHALL hold its value from the miss through WRITEBACK and ALLOCATE.
REQ-029 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 A hit increments only hit_cnt; the post-fill hit of a miss also counts as a hit.
REQ-031 pmem_read and pmem_write SHALL never be high in the same cycle.

Reset
REQ-032 reset SHALL force the following on the next clock edge, from any state including mid-WRITEBACK or mid-ALLOCATE:
- state = IDLE.
- victim = 0.
- hit_cnt = 0 and miss_cnt = 0.
REQ-033 With reset high, every output SHALL be 0 from the cycle after the edge.
REQ-034 reset SHALL take priority over any request or pmem_resp in the same cycle.

Verification
REQ-035 Read hit: mem_read=1, hit1=1 -> mem_resp in the COMPARE cycle with way_sel=1, lru_load=1, lru_in=0; hit_cnt=1.
REQ-036 Cold miss: v0=v1=0, mem_read, pmem_resp 3 cycles after ALLOCATE entry -> way_sel=0, valid_load=1 on the fill, then a hit; miss_cnt=1, hit_cnt=1.
REQ-037 Dirty eviction: v0=v1=1, lru=1, dirty1=1 -> WRITEBACK with pmem_write=1 and wb_addr_sel=1, then ALLOCATE, then COMPARE; way_sel=1 throughout.
REQ-038 Write hit on way0 -> data_load=1, dirty_load=1, dirty_in=1, way_sel=0, mem_resp=1.
REQ-039 Reset asserted during ALLOCATE with pmem_read=1 -> next cycle IDLE, pmem_read=0, counters 0; a pmem_resp arriving afterwards causes no loads.
REQ-040 Counter saturation: with CNT_W=4, 20 hits -> hit_cnt=15.
